// File: rtl/hippo_alu_issue_if.sv
// Bundle of the execute-wrapper signals: decode-side issue inputs, the ALU
// operand/result pair, and the writeback valid/ready result channel.
// The slave modport is the wrapper's view; master is the surrounding core.
interface hippo_alu_issue_if #(
    parameter int XLEN     = 32,
    parameter int RegAddrW = 5
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_rs1_data;
    logic [XLEN-1:0]     in_rs2_data;
    logic [RegAddrW-1:0] in_rs1_addr;
    logic [RegAddrW-1:0] in_rs2_addr;
    logic [RegAddrW-1:0] in_rd_addr;
    logic [XLEN-1:0]     in_pc;
    logic [XLEN-1:0]     in_imm;
    logic                in_a_sel;
    logic                in_b_sel;
    logic                in_sub_arith;
    logic [2:0]          in_op;
    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic                alu_sub_arith;
    logic [2:0]          alu_op;
    logic [XLEN-1:0]     alu_res;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_res;
    logic [RegAddrW-1:0] out_rd;

    modport slave (
        input  flush, in_valid, in_rs1_data, in_rs2_data, in_rs1_addr,
               in_rs2_addr, in_rd_addr, in_pc, in_imm, in_a_sel, in_b_sel,
               in_sub_arith, in_op, alu_res, out_ready,
        output in_ready, alu_a, alu_b, alu_sub_arith, alu_op,
               out_valid, out_res, out_rd
    );

    modport master (
        output flush, in_valid, in_rs1_data, in_rs2_data, in_rs1_addr,
               in_rs2_addr, in_rd_addr, in_pc, in_imm, in_a_sel, in_b_sel,
               in_sub_arith, in_op, alu_res, out_ready,
        input  in_ready, alu_a, alu_b, alu_sub_arith, alu_op,
               out_valid, out_res, out_rd
    );
endinterface

// File: rtl/hippo_alu_issue.sv
// Two-stage execute wrapper around the combinational ALU.
// S1 registers the selected (and forwarded) ALU operands; S2 registers the
// ALU result and offers it to writeback through a valid/ready handshake.
module hippo_alu_issue #(
    parameter int XLEN     = 32,
    parameter int RegAddrW = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    hippo_alu_issue_if.slave      bus
);

    logic                s1_valid;
    logic                s2_valid;
    logic [RegAddrW-1:0] s1_rd;
    logic [XLEN-1:0]     alu_a_q;
    logic [XLEN-1:0]     alu_b_q;
    logic                alu_sub_arith_q;
    logic [2:0]          alu_op_q;
    logic [XLEN-1:0]     out_res_q;
    logic [RegAddrW-1:0] out_rd_q;

    logic                s1_move;
    logic                accept;
    logic [XLEN-1:0]     fwd_rs1;
    logic [XLEN-1:0]     fwd_rs2;

    // S1 advances whenever S2 is empty or S2 retires in the same cycle, so
    // in_ready depends combinationally on out_ready.
    assign s1_move      = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | s1_move;
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.alu_sub_arith = alu_sub_arith_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.out_valid     = s2_valid;
    assign bus.out_res       = out_res_q;
    assign bus.out_rd        = out_rd_q;

    // Forwarding: youngest in-flight producer wins (S1 result, then S2
    // result, even if S2 is retiring now); x0 is never forwarded.
    always_comb begin
        fwd_rs1 = bus.in_rs1_data;
        fwd_rs2 = bus.in_rs2_data;
        if (bus.in_rs1_addr != '0) begin
            if (s1_valid && (s1_rd == bus.in_rs1_addr)) begin
                fwd_rs1 = bus.alu_res;
            end else if (s2_valid && (out_rd_q == bus.in_rs1_addr)) begin
                fwd_rs1 = out_res_q;
            end
        end
        if (bus.in_rs2_addr != '0) begin
            if (s1_valid && (s1_rd == bus.in_rs2_addr)) begin
                fwd_rs2 = bus.alu_res;
            end else if (s2_valid && (out_rd_q == bus.in_rs2_addr)) begin
                fwd_rs2 = out_res_q;
            end
        end
    end

    // Stage occupancy: flush empties both stages, otherwise S1 fills on
    // accept and S2 fills on S1 move or drains on retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
            if (s1_move) begin
                s2_valid <= 1'b1;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // S1 data: load selected operands on accept, hold otherwise so the ALU
    // inputs are stable during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_sub_arith_q <= 1'b0;
            alu_op_q        <= 3'd0;
            s1_rd           <= '0;
        end else if (accept) begin
            alu_a_q         <= bus.in_a_sel ? bus.in_pc  : fwd_rs1;
            alu_b_q         <= bus.in_b_sel ? bus.in_imm : fwd_rs2;
            alu_sub_arith_q <= bus.in_sub_arith;
            alu_op_q        <= bus.in_op;
            s1_rd           <= bus.in_rd_addr;
        end
    end

    // S2 data: capture the ALU result as S1 moves; a flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_res_q <= '0;
            out_rd_q  <= '0;
        end else if (s1_move && !bus.flush) begin
            out_res_q <= bus.alu_res;
            out_rd_q  <= s1_rd;
        end
    end

endmodule

// File: tb/tb_hippo_alu_issue.sv
// Self-checking bench for hippo_alu_issue. The reference model is
// architectural: a committed register file plus an in-order list of
// in-flight results; each new instruction reads the youngest in-flight
// producer of a register, else the committed value.
module tb_hippo_alu_issue;

    logic clk = 1'b0;
    logic reset = 1'b1;

    hippo_alu_issue_if #(.XLEN(32), .RegAddrW(5)) bus ();

    hippo_alu_issue #(.XLEN(32), .RegAddrW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        sub;
        logic [31:0] res;
    } entry_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] regs [32];
    entry_t      pend [$];
    logic        fresh = 1'b0;
    logic [31:0] seen [$];

    // Behavioural ALU sitting outside the wrapper.
    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input logic sub);
        case (op)
            3'd0:    return sub ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return sub ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign bus.alu_res = aluModel(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_sub_arith);

    function automatic logic [31:0] modelOperand(input logic [4:0] rs);
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (rs != 5'd0 && pend[i].rd == rs) return pend[i].res;
        end
        return regs[rs];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic sub,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic asel, input logic bsel,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic ordy, input logic fl);
        logic   rdy_exp, ov_exp, acc, ret;
        entry_t e;
        bus.in_valid     = v;
        bus.in_op        = op;
        bus.in_sub_arith = sub;
        bus.in_rs1_addr  = rs1;
        bus.in_rs2_addr  = rs2;
        bus.in_rd_addr   = rd;
        bus.in_a_sel     = asel;
        bus.in_b_sel     = bsel;
        bus.in_pc        = pc;
        bus.in_imm       = imm;
        bus.in_rs1_data  = regs[rs1];
        bus.in_rs2_data  = regs[rs2];
        bus.out_ready    = ordy;
        bus.flush        = fl;
        @(negedge clk);
        rdy_exp = (pend.size() < 2) || ordy;
        ov_exp  = (pend.size() > 0) && !(pend.size() == 1 && fresh);
        checkOutput("in_ready", 32'(bus.in_ready), 32'(rdy_exp));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(ov_exp));
        if (ov_exp && ordy) begin
            checkOutput("out_res", bus.out_res, pend[0].res);
            checkOutput("out_rd", 32'(bus.out_rd), 32'(pend[0].rd));
        end
        if (fresh || pend.size() == 2) begin
            e = pend[pend.size() - 1];
            checkOutput("alu_a", bus.alu_a, e.a);
            checkOutput("alu_b", bus.alu_b, e.b);
            checkOutput("alu_op", 32'(bus.alu_op), 32'(e.op));
            checkOutput("alu_sub", 32'(bus.alu_sub_arith), 32'(e.sub));
        end
        acc = v && rdy_exp && !fl && !reset;
        ret = ov_exp && ordy && !reset;
        if (acc) begin
            e.rd  = rd;
            e.a   = asel ? pc  : modelOperand(rs1);
            e.b   = bsel ? imm : modelOperand(rs2);
            e.op  = op;
            e.sub = sub;
            e.res = aluModel(e.a, e.b, op, sub);
        end
        if (ret) seen.push_back(bus.out_res);
        @(posedge clk);
        #1;
        fresh = 1'b0;
        if (ret) begin
            if (pend[0].rd != 5'd0) regs[pend[0].rd] = pend[0].res;
            void'(pend.pop_front());
        end
        if (fl || reset) begin
            pend.delete();
        end else if (acc) begin
            pend.push_back(e);
            fresh = 1'b1;
        end
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    task automatic addRR(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ordy);
        applyStimulus(1'b1, 3'd0, 1'b0, rs1, rs2, rd, 1'b0, 1'b0, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    task automatic addRI(input logic [4:0] rs1, input logic [31:0] imm, input logic [4:0] rd,
                         input logic ordy);
        applyStimulus(1'b1, 3'd0, 1'b0, rs1, 5'd0, rd, 1'b0, 1'b1, 32'd0, imm, ordy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[10] = 32'd5;
        regs[11] = 32'd7;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_sub_arith = 1'b0;
        bus.in_rs1_addr = 5'd0; bus.in_rs2_addr = 5'd0; bus.in_rd_addr = 5'd0;
        bus.in_a_sel = 1'b0; bus.in_b_sel = 1'b0; bus.in_pc = 32'd0; bus.in_imm = 32'd0;
        bus.in_rs1_data = 32'd0; bus.in_rs2_data = 32'd0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_alu_a", bus.alu_a, 32'd0);
        checkOutput("rst_alu_b", bus.alu_b, 32'd0);
        checkOutput("rst_alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("rst_alu_sub", 32'(bus.alu_sub_arith), 32'd0);
        checkOutput("rst_out_res", bus.out_res, 32'd0);
        checkOutput("rst_out_rd", 32'(bus.out_rd), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;

        // Single ADD, then the S1/S2 forwarding chain.
        seen.delete();
        addRR(5'd10, 5'd11, 5'd1, 1'b1);
        addRI(5'd1, 32'd3, 5'd2, 1'b1);
        addRR(5'd1, 5'd2, 5'd3, 1'b1);
        repeat (3) idle(1'b1);
        checkOutput("chain_count", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            checkOutput("chain_i1", seen[0], 32'd12);
            checkOutput("chain_i2", seen[1], 32'd15);
            checkOutput("chain_i3", seen[2], 32'd27);
        end

        // Backpressure: three offered, two held, then drained in order.
        seen.delete();
        addRR(5'd10, 5'd10, 5'd5, 1'b0);
        addRR(5'd11, 5'd11, 5'd6, 1'b0);
        addRR(5'd10, 5'd11, 5'd7, 1'b0);
        repeat (3) idle(1'b0);
        repeat (3) idle(1'b1);
        checkOutput("stall_count", seen.size(), 32'd2);
        if (seen.size() == 2) begin
            checkOutput("stall_i1", seen[0], 32'd10);
            checkOutput("stall_i2", seen[1], 32'd14);
        end

        // rd=0 never forwards; pc+imm path.
        seen.delete();
        addRI(5'd10, 32'd4, 5'd0, 1'b1);
        addRI(5'd0, 32'd1, 5'd4, 1'b1);
        applyStimulus(1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1,
                      32'h100, 32'd4, 1'b1, 1'b0);
        repeat (3) idle(1'b1);
        checkOutput("rd0_count", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            checkOutput("rd0_i1", seen[0], 32'd9);
            checkOutput("rd0_i2", seen[1], 32'd1);
            checkOutput("pc_imm", seen[2], 32'h104);
        end

        // Flush with two stalled instructions and a new one offered.
        addRR(5'd10, 5'd11, 5'd9, 1'b0);
        addRR(5'd11, 5'd10, 5'd9, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b0, 5'd10, 5'd10, 5'd12, 1'b0, 1'b0,
                      32'd0, 32'd0, 1'b0, 1'b1);
        repeat (3) idle(1'b1);

        // Reset asserted mid-stall.
        addRR(5'd10, 5'd11, 5'd13, 1'b0);
        addRR(5'd11, 5'd10, 5'd14, 1'b0);
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        idle(1'b0);
        checkOutput("rst_stall_alu_a", bus.alu_a, 32'd0);

        // Randomized traffic with frequent hazards on a small register set.
        for (int i = 1; i < 8; i++) regs[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            logic fl, ordy;
            fl   = ($urandom_range(0, 99) < 3);
            ordy = fl ? 1'b0 : ($urandom_range(0, 99) < 70);
            applyStimulus($urandom_range(0, 99) < 75, 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                          $urandom, $urandom, ordy, fl);
        end
        repeat (4) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
